// File: rtl/reg_pkg.sv
// Shared definitions for the register bank write and read-back paths.
package reg_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int BANK_DEPTH = 1 << ADDR_W_DEF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAP,
    SHIFT,
    DONE
  } state_t;

  // Width of a counter that indexes bits 0..w-1 (never narrower than one bit).
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, LSB-first shift register; load has priority over shift.
module piso_shift
  import reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= d;
    end else if (shift) begin
      sr <= sr >> 1;
    end
  end

  assign q = sr[0];

endmodule

// File: rtl/reg_reader.sv
// Burst read-back engine: reads consecutive bank words and serialises each
// one LSB-first, with a parallel copy of every captured word.
module reg_reader
  import reg_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              bank_rd,
  output logic [ADDR_W-1:0] bank_addr,
  input  logic [WIDTH-1:0]  bank_q,
  output logic [WIDTH-1:0]  word,
  output logic              word_valid,
  output logic              sdo,
  output logic              sdo_valid,
  output logic              done
);

  localparam int BW = cnt_w(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remaining;
  logic [BW-1:0]     bitcnt;
  logic              sr_load;
  logic              sr_shift;
  logic              sr_bit;

  // The bank is registered, so bank_q is valid throughout CAP.
  assign sr_load  = (state == CAP);
  assign sr_shift = (state == SHIFT);

  piso_shift #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (sr_load),
    .shift (sr_shift),
    .d     (bank_q),
    .q     (sr_bit)
  );

  // Gate with sdo_valid so the line idles low between words.
  assign sdo = sr_bit & sdo_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      bitcnt     <= '0;
      busy       <= 1'b0;
      bank_rd    <= 1'b0;
      bank_addr  <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      sdo_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base;
            remaining <= count;
            bank_rd   <= 1'b1;
            bank_addr <= base;
            busy      <= 1'b1;
            state     <= REQ;
          end
        end

        REQ: begin
          bank_rd <= 1'b0;
          state   <= CAP;
        end

        CAP: begin
          word       <= bank_q;
          word_valid <= 1'b1;
          sdo_valid  <= 1'b1;
          bitcnt     <= '0;
          state      <= SHIFT;
        end

        SHIFT: begin
          word_valid <= 1'b0;
          bitcnt     <= bitcnt + BW'(1);
          if (bitcnt == LAST_BIT) begin
            sdo_valid <= 1'b0;
            if (remaining == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              remaining <= remaining - ADDR_W'(1);
              addr      <= addr + ADDR_W'(1);
              bank_rd   <= 1'b1;
              bank_addr <= addr + ADDR_W'(1);
              state     <= REQ;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_reader.sv
// Directed bench for reg_reader with a registered bank model and scoreboards
// for read addresses, captured words and serial bits.
module tb_reg_reader;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] base;
  logic [2:0] count;
  logic       busy;
  logic       bank_rd;
  logic [2:0] bank_addr;
  logic [7:0] bank_q;
  logic [7:0] word;
  logic       word_valid;
  logic       sdo;
  logic       sdo_valid;
  logic       done;

  reg_reader #(.WIDTH(8), .ADDR_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base       (base),
    .count      (count),
    .busy       (busy),
    .bank_rd    (bank_rd),
    .bank_addr  (bank_addr),
    .bank_q     (bank_q),
    .word       (word),
    .word_valid (word_valid),
    .sdo        (sdo),
    .sdo_valid  (sdo_valid),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [8];

  initial bank_q = 8'h00;
  always @(posedge clk) if (bank_rd) bank_q <= mem[bank_addr];

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [2:0] exp_addr [$];
  logic [7:0] exp_word [$];
  logic       exp_bit  [$];

  int ncyc     = 0;
  int last_wv  = -1;
  int gap_bad  = 0;
  int wv_cnt   = 0;
  int sv_cnt   = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  bit saw5     = 0;

  // Output monitor, sampling at the falling edge.
  always @(negedge clk) begin
    ncyc++;
    if (bank_rd) begin
      if (exp_addr.size() == 0) chk("addr_extra", 32'(bank_addr), 32'hFFFF);
      else chk("addr", 32'(bank_addr), 32'(exp_addr.pop_front()));
    end
    if (word_valid) begin
      wv_cnt++;
      if (last_wv >= 0 && ncyc - last_wv != 10) gap_bad++;
      last_wv = ncyc;
      if (exp_word.size() == 0) chk("word_extra", 32'(word), 32'hFFFF);
      else chk("word", 32'(word), 32'(exp_word.pop_front()));
    end
    if (sdo_valid) begin
      sv_cnt++;
      if (exp_bit.size() == 0) chk("sdo_extra", 32'(sdo), 32'hFFFF);
      else chk("sdo", 32'(sdo), 32'(exp_bit.pop_front()));
    end
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (bank_addr == 3'd5) saw5 = 1'b1;
  end

  int cyc = 0;

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic push_word(input logic [2:0] a, input int nbits);
    logic [7:0] v;
    v = mem[a];
    exp_addr.push_back(a);
    exp_word.push_back(v);
    for (int i = 0; i < nbits; i++) exp_bit.push_back(v[i]);
  endtask

  task automatic begin_burst(input logic [2:0] b, input logic [2:0] c);
    wv_cnt = 0; sv_cnt = 0; busy_cnt = 0; done_cnt = 0; last_wv = -1; gap_bad = 0;
    cyc   = 0;
    start = 1'b1;
    base  = b;
    count = c;
    step();
    start = 1'b0;
    base  = 3'd0;
    count = 3'd0;
  endtask

  task automatic run_to_done(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit && at < 0; i++) begin
      step();
      if (done) at = cyc;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_rd"},    32'(bank_rd),    32'd0);
    chk({tag, "_addr"},  32'(bank_addr),  32'd0);
    chk({tag, "_word"},  32'(word),       32'd0);
    chk({tag, "_wv"},    32'(word_valid), 32'd0);
    chk({tag, "_sdo"},   32'(sdo),        32'd0);
    chk({tag, "_sv"},    32'(sdo_valid),  32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    for (int i = 0; i < 8; i++) mem[i] = 8'(i * 8'h11);
    mem[2] = 8'hA5;
    start = 1'b0;
    base  = 3'd0;
    count = 3'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    step();
    step();
    chk_all_zero("rst");
    reset = 1'b1;
    step();

    // Single word at address 2.
    push_word(3'd2, 8);
    begin_burst(3'd2, 3'd0);
    chk("t1_rd_c1",   32'(bank_rd),   32'd1);
    chk("t1_addr_c1", 32'(bank_addr), 32'd2);
    chk("t1_busy_c1", 32'(busy),      32'd1);
    chk("t1_sv_c1",   32'(sdo_valid), 32'd0);
    step();
    chk("t1_rd_c2",   32'(bank_rd),    32'd0);
    chk("t1_wv_c2",   32'(word_valid), 32'd0);
    step();
    chk("t1_wv_c3",   32'(word_valid), 32'd1);
    chk("t1_word_c3", 32'(word),       32'hA5);
    chk("t1_sdo_c3",  32'(sdo),        32'd1);
    step();
    chk("t1_wv_c4",   32'(word_valid), 32'd0);
    chk("t1_word_c4", 32'(word),       32'hA5);
    for (int i = 0; i < 6; i++) step();
    chk("t1_sv_c10",  32'(sdo_valid), 32'd1);
    chk("t1_sdo_c10", 32'(sdo),       32'd1);
    step();
    chk("t1_done_c11", 32'(done),      32'd1);
    chk("t1_busy_c11", 32'(busy),      32'd1);
    chk("t1_sv_c11",   32'(sdo_valid), 32'd0);
    step();
    chk("t1_done_c12", 32'(done), 32'd0);
    chk("t1_busy_c12", 32'(busy), 32'd0);
    mem[2] = 8'h22;

    // Wrapping burst 6,7,0,1.
    push_word(3'd6, 8);
    push_word(3'd7, 8);
    push_word(3'd0, 8);
    push_word(3'd1, 8);
    begin_burst(3'd6, 3'd3);
    run_to_done(60, at);
    chk("t2_done_cycle", 32'(at), 32'd41);
    step();
    chk("t2_wv_cnt", 32'(wv_cnt), 32'd4);

    // Full eight-word burst.
    for (int a = 0; a < 8; a++) push_word(3'(a), 8);
    begin_burst(3'd0, 3'd7);
    run_to_done(120, at);
    chk("t3_done_cycle", 32'(at), 32'd81);
    step();
    chk("t3_wv_cnt",   32'(wv_cnt),   32'd8);
    chk("t3_sv_cnt",   32'(sv_cnt),   32'd64);
    chk("t3_busy_cnt", 32'(busy_cnt), 32'd81);
    chk("t3_gap_bad",  32'(gap_bad),  32'd0);

    // Start pulses while busy and in DONE are ignored.
    saw5 = 1'b0;
    push_word(3'd2, 8);
    begin_burst(3'd2, 3'd0);
    for (int i = 0; i < 3; i++) step();
    start = 1'b1; base = 3'd5;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("t4_done_c11", 32'(done), 32'd1);
    start = 1'b1; base = 3'd5;
    step();
    start = 1'b0; base = 3'd0;
    for (int i = 0; i < 15; i++) step();
    chk("t4_busy_after", 32'(busy),     32'd0);
    chk("t4_saw_addr5",  32'(saw5),     32'd0);
    chk("t4_done_cnt",   32'(done_cnt), 32'd1);

    // Reset in cycle 6 of a two-word burst.
    exp_addr.push_back(3'd3);
    exp_word.push_back(mem[3]);
    for (int i = 0; i < 3; i++) exp_bit.push_back(mem[3][i]);
    begin_burst(3'd3, 3'd1);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b0;
    #1;
    chk_all_zero("t5_rst");
    for (int i = 0; i < 3; i++) step();
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    reset = 1'b1;
    step();
    push_word(3'd4, 8);
    begin_burst(3'd4, 3'd0);
    chk("t5_rd_c1",   32'(bank_rd),   32'd1);
    chk("t5_addr_c1", 32'(bank_addr), 32'd4);
    step();
    step();
    chk("t5_wv_c3",   32'(word_valid), 32'd1);
    chk("t5_word_c3", 32'(word),       32'h44);
    run_to_done(20, at);
    chk("t5_done_cycle", 32'(at), 32'd11);
    step();
    step();

    chk("q_addr_left", 32'(exp_addr.size()), 32'd0);
    chk("q_word_left", 32'(exp_word.size()), 32'd0);
    chk("q_bit_left",  32'(exp_bit.size()),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
